axil_req_arbiter: RTL
=====================

// Module: axil_req_arbiter
// PURPOSE
//  Shares one AXI4-Lite master port between N_REQ simple request/response clients (CPU bridge,
//  debug UART, self-test sequencer) that all need access to the REGPOOL register file.
//  Round-robin grant, one outstanding transaction at a time, full AW/W/B and AR/R sequencing.
//  Sits between the clients and the REGPOOL AXIL slave port.
// PARAMETERS
//  N_REQ       4   number of requesters (2..8)
//  ADDR_WIDTH  32  AXI address width
//  DATA_WIDTH  32  AXI data width; WSTRB is all ones
// PORTS
//  ACLK        in   1              clock
//  ARESETN     in   1              reset, asynchronous, active-low
//  req_valid   in   N_REQ          per-client request pending
//  req_ready   out  N_REQ          one-hot; request accepted this cycle
//  req_we      in   N_REQ          1=write, 0=read
//  req_addr    in   N_REQ*ADDR_W   client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_wdata   in   N_REQ*DATA_W   client i at [i*DATA_WIDTH +: DATA_WIDTH]
//  rsp_valid   out  N_REQ          one-hot, 1-cycle pulse, transaction completed
//  rsp_rdata   out  DATA_WIDTH     read data, valid with rsp_valid (0 for writes)
//  rsp_err     out  1              RESP[1] of BRESP/RRESP, valid with rsp_valid
//  busy        out  1              FSM not in IDLE
//  AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY,
//  ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY   AXI4-Lite master, standard dirs/widths
// BEHAVIOUR
//  Reset: all outputs 0 (req_ready, rsp_valid, *VALID, *READY, busy, rsp_*); rr pointer = 0;
//   FSM = IDLE. Async assertion mid-transaction aborts immediately; no response pulse issued.
//  FSM: IDLE -> WR_ADDR | RD_ADDR -> WR_RESP | RD_DATA -> DONE -> IDLE.
//  IDLE: if any req_valid, grant = first set bit at or after rr pointer (wrapping N_REQ-1 -> 0).
//   req_ready[grant]=1 for that single cycle; addr/wdata/we latched into holding regs.
//   No req_valid: stay IDLE, req_ready=0.
//  WR_ADDR: AWVALID and WVALID asserted together next cycle; each dropped independently on
//   its own handshake (AWREADY or WREADY, any order, same cycle allowed). Leave when both done.
//  WR_RESP: BREADY=1; on BVALID capture BRESP -> DONE.
//  RD_ADDR: ARVALID=1 until ARREADY -> RD_DATA. RD_DATA: RREADY=1; on RVALID capture
//   RDATA/RRESP -> DONE.
//  VALID signals never drop before handshake; address/data stable while VALID high.
//  DONE: rsp_valid[grant]=1 one cycle, rsp_rdata/rsp_err valid; rr pointer = grant+1 mod N_REQ.
//  Minimum latency with zero-wait slave: req_ready @T, AXI VALID @T+1, resp @T+2, rsp_valid @T+3;
//   next grant earliest @T+4.
//  Clients must hold req_valid/we/addr/wdata until req_ready; deasserting earlier is allowed and
//   simply withdraws the request (no grant taken). Client may re-request in its rsp_valid cycle.
//  Simultaneous requests: only one granted per IDLE visit; losers wait, no starvation
//   (each waits at most N_REQ-1 transactions).
//  SLVERR/DECERR: rsp_err=1, transaction otherwise normal; no retry.
//  No timeout: a non-responding slave hangs the FSM until reset (busy stays 1).
// TESTING
//  1 Reset: ARESETN low 10 cycles -> all outputs 0; release -> busy=0, rr=0.
//  2 Single read: client1 reads TIMESTAMP_LOWER_OFFSET -> rsp_valid=4'b0010, rdata tracks counter,
//    rsp_err=0, latency 3 cycles from req_ready with ready slave.
//  3 Write/readback: client0 writes 32'hdeadbeef to CORE_CONFIGURATION_OFFSET, then reads ->
//    rsp_rdata=32'hdeadbeef; AWREADY delayed 3 cycles vs WREADY 0 -> still one B handshake.
//  4 Fairness: all 4 clients hold req_valid continuously 12 transactions -> grant order
//    0,1,2,3,0,1,2,3,...; never two req_ready bits in one cycle.
//  5 Error: read unmapped address 0xFFFF_FFF0 -> rsp_err=1, rsp_rdata=slave RDATA, FSM to IDLE.
//  6 Reset mid-op: assert ARESETN during WR_RESP -> AXI VALIDs/READYs and busy drop immediately;
//    after release a new read completes normally.

Source files
------------

// File: rtl/axil_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port among N_REQ
// request/response clients, one outstanding transaction at a time.
module axil_req_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0]            req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_rdata,
  output logic                        rsp_err,
  output logic                        busy,
  output logic [ADDR_WIDTH-1:0]       AWADDR,
  output logic                        AWVALID,
  input  logic                        AWREADY,
  output logic [DATA_WIDTH-1:0]       WDATA,
  output logic [DATA_WIDTH/8-1:0]     WSTRB,
  output logic                        WVALID,
  input  logic                        WREADY,
  input  logic [1:0]                  BRESP,
  input  logic                        BVALID,
  output logic                        BREADY,
  output logic [ADDR_WIDTH-1:0]       ARADDR,
  output logic                        ARVALID,
  input  logic                        ARREADY,
  input  logic [DATA_WIDTH-1:0]       RDATA,
  input  logic [1:0]                  RRESP,
  input  logic                        RVALID,
  output logic                        RREADY
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           rr_q, grant_q, pick;
  logic                    any, pick_we;
  logic [ADDR_WIDTH-1:0]   pick_addr, addr_q;
  logic [DATA_WIDTH-1:0]   pick_wdata, wdata_q, rdata_q;
  logic                    err_q, aw_pend, w_pend;
  logic                    aw_done, w_done;
  int                      idx;

  // First pending client at or after the rr pointer, wrapping.
  always_comb begin
    any        = 1'b0;
    pick       = '0;
    pick_we    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    idx        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_q) + k) % N_REQ;
      if (!any && req_valid[idx]) begin
        any        = 1'b1;
        pick       = IW'(idx);
        pick_we    = req_we[idx];
        pick_addr  = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
        pick_wdata = req_wdata[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign aw_done = !aw_pend || AWREADY;
  assign w_done  = !w_pend || WREADY;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any) state_d = pick_we ? WR_ADDR : RD_ADDR;
      WR_ADDR: if (aw_done && w_done) state_d = WR_RESP;
      WR_RESP: if (BVALID) state_d = DONE;
      RD_ADDR: if (ARREADY) state_d = RD_DATA;
      RD_DATA: if (RVALID) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (any) begin
          grant_q <= pick;
          addr_q  <= pick_addr;
          wdata_q <= pick_wdata;
          aw_pend <= pick_we;
          w_pend  <= pick_we;
        end
        WR_ADDR: begin
          if (AWREADY) aw_pend <= 1'b0;
          if (WREADY)  w_pend  <= 1'b0;
        end
        WR_RESP: if (BVALID) begin
          rdata_q <= '0;
          err_q   <= BRESP[1];
        end
        RD_DATA: if (RVALID) begin
          rdata_q <= RDATA;
          err_q   <= RRESP[1];
        end
        DONE: rr_q <= (grant_q == IW'(N_REQ-1))
                      ? '0 : grant_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Reset gates the combinational grant so outputs read zero in reset.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (ARESETN && state_q == IDLE && any)
      req_ready[pick] = 1'b1;
    if (state_q == DONE)
      rsp_valid[grant_q] = 1'b1;
  end

  assign rsp_rdata = (state_q == DONE) ? rdata_q : '0;
  assign rsp_err   = (state_q == DONE) && err_q;
  assign busy      = (state_q != IDLE);

  assign AWADDR  = addr_q;
  assign AWVALID = aw_pend;
  assign WDATA   = wdata_q;
  assign WSTRB   = '1;
  assign WVALID  = w_pend;
  assign BREADY  = (state_q == WR_RESP);
  assign ARADDR  = addr_q;
  assign ARVALID = (state_q == RD_ADDR);
  assign RREADY  = (state_q == RD_DATA);

  logic unused_resp;
  assign unused_resp = ^{BRESP[0], RRESP[0]};

endmodule
